// File: rtl/gpio_bus_if.sv
// Word-addressed register bus between the CPU and the GPIO input peripheral.
// The master drives address, write strobe and write data; the slave returns combinational read data.
interface gpio_bus_if;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/gpio_input_ctrl.sv
// Debounced byte-wide board inputs with per-channel change flags and one maskable interrupt.
// Build option GPIO_DEBOUNCE_EN: defined = counter-based debounce, undefined = pass-through after sync.
module gpio_input_ctrl #(
    parameter int NUM_CH          = 9,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH*8-1:0]   sw_in,
    gpio_bus_if.slave             bus,
    output logic                  irq
);

    localparam logic [4:0] CTRL_IDX = 5'(NUM_CH);
    localparam logic [4:0] STAT_IDX = 5'(NUM_CH + 1);

    logic [NUM_CH*8-1:0] sync1_r;
    logic [NUM_CH*8-1:0] sync2_r;
    logic [NUM_CH*8-1:0] stable_r;
    logic [NUM_CH*8-1:0] stable_nxt_s;
    logic [NUM_CH-1:0]   stat_r;
    logic [NUM_CH-1:0]   stat_nxt_s;
    logic [NUM_CH-1:0]   set_s;
    logic [NUM_CH-1:0]   clr_s;
    logic                ie_r;
    logic                ie_nxt_s;
    logic                irq_r;
    logic [7:0]          val_sel_s;
    logic [31:0]         rdata_s;
    logic                unused_wdata_s;

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r     [NUM_CH];
    logic [CNT_W-1:0] cnt_nxt_s [NUM_CH];

    // Whole-byte debounce: any return to the stable pattern restarts the count.
    always_comb begin
        stable_nxt_s = stable_r;
        set_s        = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
            if (sync2_r[i*8 +: 8] == stable_r[i*8 +: 8]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i*8 +: 8] = sync2_r[i*8 +: 8];
                set_s[i]               = 1'b1;
                cnt_nxt_s[i]           = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] unused_cfg_s;
    assign unused_cfg_s = CNT_W'(DEBOUNCE_CYCLES);

    // Without debounce the synchronised value is accepted every cycle.
    always_comb begin
        stable_nxt_s = sync2_r;
        set_s        = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            set_s[i] = (sync2_r[i*8 +: 8] != stable_r[i*8 +: 8]);
        end
    end
`endif

    // Register writes: W1C clears on STAT, IE on CTRL; a same-cycle set beats the clear.
    always_comb begin
        if (bus.we && (bus.addr == STAT_IDX)) begin
            clr_s = bus.wdata[NUM_CH-1:0];
        end else begin
            clr_s = {NUM_CH{1'b0}};
        end
        if (bus.we && (bus.addr == CTRL_IDX)) begin
            ie_nxt_s = bus.wdata[0];
        end else begin
            ie_nxt_s = ie_r;
        end
        stat_nxt_s = (stat_r & ~clr_s) | set_s;
    end

    assign unused_wdata_s = ^bus.wdata[31:NUM_CH];

    // Synchroniser, stable values, flags, IE and the registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r  <= {(NUM_CH*8){1'b0}};
            sync2_r  <= {(NUM_CH*8){1'b0}};
            stable_r <= {(NUM_CH*8){1'b0}};
            stat_r   <= {NUM_CH{1'b0}};
            ie_r     <= 1'b0;
            irq_r    <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
`endif
        end else begin
            sync1_r  <= sw_in;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            stat_r   <= stat_nxt_s;
            ie_r     <= ie_nxt_s;
            // Follows the flag/IE state one edge after it changes.
            irq_r    <= ie_r & (|stat_r);
`ifdef GPIO_DEBOUNCE_EN
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
`endif
        end
    end

    // Stable-value mux for the VAL window.
    always_comb begin
        val_sel_s = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            val_sel_s = val_sel_s | ((bus.addr == 5'(i)) ? stable_r[i*8 +: 8] : 8'h00);
        end
    end

    // Zero-wait-state read decode; unmapped indices read zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (bus.addr < CTRL_IDX) begin
            rdata_s = {24'h00_0000, val_sel_s};
        end else if (bus.addr == CTRL_IDX) begin
            rdata_s = {31'h0000_0000, ie_r};
        end else if (bus.addr == STAT_IDX) begin
            rdata_s = {{(32-NUM_CH){1'b0}}, stat_r};
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata = rdata_s;
    assign irq       = irq_r;

endmodule
